// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants, word-length decode.
// Latency: n/a (package only).
// Backpressure: n/a; imported by both the receiver and the transmitter.
package uart_pkg;

   // Oversample pulses per bit, and the pulse count from the start edge to mid start bit.
   localparam int OVS  = 16;
   localparam int HALF = 7;

   // Five states do not fit in 2 bits, so the encoding is 3 bits.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // wls 00..11 selects a 5..8 bit character.
   function automatic logic [3:0] word_len(input logic [1:0] wls);
      return 4'd5 + {2'b00, wls};
   endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk.
// Backpressure: none; samples every clk.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module uart_sync_bit #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling, parity/framing/break checks.
// Latency: push on the baud pulse 8+16*(N+P+1) after the start edge (N data bits, P parity bit).
// Backpressure: none; push is a one-clk strobe into the RX FIFO, which must accept it.
// Ports: clk, rst_n, baud_pulse (16x strobe), rx (async serial in), pen/eps/sticky_parity/wls
//        (line control), push (write strobe), dout (right-justified word), pe/fe/bi (status, valid with push).
module uart_rx_top #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic [1:0] wls,
   output logic       push,
   output logic [7:0] dout,
   output logic       pe,
   output logic       fe,
   output logic       bi
);

   import uart_pkg::*;

   localparam logic [3:0] BIT_RELOAD = 4'(OVS - 1);
   localparam logic [3:0] HALF_LOAD  = 4'(HALF);

   logic        rxs;
   uart_state_t state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        prev_q, prev_d;
   logic        push_q, push_d;
   logic [7:0]  dout_q, dout_d;
   logic        pe_q, pe_d;
   logic        fe_q, fe_d;
   logic        bi_q, bi_d;
   logic [7:0]  data_word;
   logic        exp_par;

   uart_sync_bit #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rxs)
   );

   // Bits enter at the MSB and move right, so after N shifts the word sits in
   // shift_q[7:8-N]; shifting right by 8-N right-justifies it and zero-fills the top.
   assign data_word = shift_q >> (2'd3 - wls);

   always_comb begin
      exp_par = 1'b0;
      case ({sticky_parity, eps})
         2'b00:   exp_par = ~^data_word;
         2'b01:   exp_par = ^data_word;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         prev_q   <= 1'b1;
         push_q   <= 1'b0;
         dout_q   <= '0;
         pe_q     <= 1'b0;
         fe_q     <= 1'b0;
         bi_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         prev_q   <= prev_d;
         push_q   <= push_d;
         dout_q   <= dout_d;
         pe_q     <= pe_d;
         fe_q     <= fe_d;
         bi_q     <= bi_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      prev_d   = prev_q;
      push_d   = 1'b0;          // strobe drops on the next clk whatever baud_pulse does
      dout_d   = dout_q;
      pe_d     = pe_q;
      fe_d     = fe_q;
      bi_d     = bi_q;

      if (baud_pulse) begin
         prev_d = rxs;
         case (state_q)
            ST_IDLE: begin
               // Edge-qualified so a line stuck low (break) cannot start a new frame.
               if (!rxs && prev_q) begin
                  state_d = ST_START;
                  count_d = HALF_LOAD;
               end
            end
            ST_START: begin
               if (count_q != 4'd0) begin
                  count_d = count_q - 4'd1;
               end else if (!rxs) begin
                  state_d  = ST_DATA;
                  count_d  = BIT_RELOAD;
                  bitcnt_d = word_len(wls);
                  shift_d  = '0;
               end else begin
                  state_d = ST_IDLE;    // glitch, not a real start bit
               end
            end
            ST_DATA: begin
               if (count_q != 4'd0) begin
                  count_d = count_q - 4'd1;
               end else begin
                  shift_d  = {rxs, shift_q[7:1]};
                  count_d  = BIT_RELOAD;
                  bitcnt_d = bitcnt_q - 4'd1;
                  if (bitcnt_q == 4'd1) begin
                     state_d = pen ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (count_q != 4'd0) begin
                  count_d = count_q - 4'd1;
               end else begin
                  par_d   = rxs;
                  state_d = ST_STOP;
                  count_d = BIT_RELOAD;
               end
            end
            ST_STOP: begin
               if (count_q != 4'd0) begin
                  count_d = count_q - 4'd1;
               end else begin
                  push_d  = 1'b1;
                  dout_d  = data_word;
                  pe_d    = pen & (par_q != exp_par);
                  fe_d    = ~rxs;
                  // Break: every sampled bit of the frame, stop included, was low.
                  bi_d    = (data_word == 8'd0) & ~(pen & par_q) & ~rxs;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign push = push_q;
   assign dout = dout_q;
   assign pe   = pe_q;
   assign fe   = fe_q;
   assign bi   = bi_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed frames plus random frames against a frame-level model.
module tb_uart_rx_top;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       baud_pulse = 1'b0;
   logic       rx = 1'b1;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       sticky_parity = 1'b0;
   logic [1:0] wls = 2'b11;
   logic       push;
   logic [7:0] dout;
   logic       pe;
   logic       fe;
   logic       bi;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int div = 0;

   typedef struct {
      logic [7:0] dout;
      logic       pe;
      logic       fe;
      logic       bi;
      int         idx;
   } ev_t;

   ev_t evq[$];
   ev_t mon_ev;

   uart_rx_top #(.OVS(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .baud_pulse    (baud_pulse),
      .rx            (rx),
      .pen           (pen),
      .eps           (eps),
      .sticky_parity (sticky_parity),
      .wls           (wls),
      .push          (push),
      .dout          (dout),
      .pe            (pe),
      .fe            (fe),
      .bi            (bi)
   );

   always #5 clk = ~clk;

   // baud_pulse: one clk in every three.
   initial begin
      forever begin
         @(negedge clk);
         baud_pulse = (div == 2);
         div = (div + 1) % 3;
      end
   end

   always @(posedge clk) begin
      if (baud_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   // Capture every push together with the index of the baud pulse it occurred on.
   always @(negedge clk) begin
      if (push === 1'b1) begin
         mon_ev.dout = dout;
         mon_ev.pe   = pe;
         mon_ev.fe   = fe;
         mon_ev.bi   = bi;
         mon_ev.idx  = pulse_cnt;
         evq.push_back(mon_ev);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pulses(input int n);
      repeat (n) @(posedge clk iff baud_pulse);
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_pulses(16);
   endtask

   // Expected parity bit for a character from the line-control rules.
   function automatic logic exp_parity(input logic [7:0] data, input int n, input logic e, input logic sp);
      logic [7:0] d;
      int ones;
      d = data & 8'((1 << n) - 1);
      ones = $countones(d);
      if (sp) return ~e;
      return e ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
   endfunction

   // Frame-level model: returns {dout, pe, fe, bi}.
   function automatic logic [10:0] model(input logic [7:0] data, input int n, input logic p_en,
                                         input logic e, input logic sp, input logic pb, input logic sb);
      logic [7:0] d;
      logic       m_pe, m_fe, m_bi;
      d    = data & 8'((1 << n) - 1);
      m_pe = p_en && (pb != exp_parity(data, n, e, sp));
      m_fe = !sb;
      m_bi = (d == 8'd0) && (!p_en || !pb) && !sb;
      return {d, m_pe, m_fe, m_bi};
   endfunction

   task automatic send_frame(input logic [7:0] data, input logic pb, input logic sb, output int edge_idx);
      int n;
      n = 5 + int'(wls);
      wait_pulses(1);
      edge_idx = pulse_cnt + 1;   // first baud pulse to see the synchronized low
      send_bit(1'b0);
      for (int i = 0; i < n; i++) send_bit(data[i]);
      if (pen) send_bit(pb);
      send_bit(sb);
      rx = 1'b1;
      wait_pulses(16);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] data, input logic pb,
                               input logic sb, input int edge_idx);
      logic [10:0] m;
      ev_t e;
      int n;
      n = 5 + int'(wls);
      m = model(data, n, pen, eps, sticky_parity, pb, sb);
      check({tag, "_push_count"}, evq.size(), 1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         check({tag, "_dout"}, e.dout, m[10:3]);
         check({tag, "_pe"}, e.pe, m[2]);
         check({tag, "_fe"}, e.fe, m[1]);
         check({tag, "_bi"}, e.bi, m[0]);
         check({tag, "_latency"}, e.idx - edge_idx, 8 + 16 * (n + int'(pen) + 1));
      end
      evq.delete();
   endtask

   initial begin
      int ei;
      logic [7:0] d;
      logic pb, sb;
      ev_t e;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_push", push, 1'b0);
      check("rst_dout", dout, 8'h00);
      check("rst_pe", pe, 1'b0);
      check("rst_fe", fe, 1'b0);
      check("rst_bi", bi, 1'b0);
      rst_n = 1'b1;
      wait_pulses(20);
      check("idle_no_push", evq.size(), 0);

      // 8N1, 0x5A
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1, ei);
      expect_frame("f5a", 8'h5A, 1'b0, 1'b1, ei);

      // 5 bits, even-select parity: correct then wrong parity bit
      wls = 2'b00; pen = 1'b1; eps = 1'b1;
      send_frame(8'h13, 1'b1, 1'b1, ei);
      expect_frame("p13_ok", 8'h13, 1'b1, 1'b1, ei);
      send_frame(8'h13, 1'b0, 1'b1, ei);
      expect_frame("p13_bad", 8'h13, 1'b0, 1'b1, ei);

      // 7 bits, stick parity expecting 1
      wls = 2'b10; sticky_parity = 1'b1; eps = 1'b0;
      send_frame(8'h55, 1'b0, 1'b1, ei);
      expect_frame("stick0", 8'h55, 1'b0, 1'b1, ei);
      send_frame(8'h55, 1'b1, 1'b1, ei);
      expect_frame("stick1", 8'h55, 1'b1, 1'b1, ei);

      // False start then a valid frame
      wls = 2'b11; pen = 1'b0; sticky_parity = 1'b0;
      wait_pulses(1);
      rx = 1'b0;
      wait_pulses(4);
      rx = 1'b1;
      wait_pulses(12);
      check("false_start_no_push", evq.size(), 0);
      send_frame(8'hA5, 1'b0, 1'b1, ei);
      expect_frame("fa5", 8'hA5, 1'b0, 1'b1, ei);

      // Break: line low for 20 bit times
      wls = 2'b11; pen = 1'b1; eps = 1'b1;
      wait_pulses(1);
      ei = pulse_cnt + 1;
      rx = 1'b0;
      wait_pulses(20 * 16);
      check("brk_push_count", evq.size(), 1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         check("brk_dout", e.dout, 8'h00);
         check("brk_pe", e.pe, 1'b0);
         check("brk_fe", e.fe, 1'b1);
         check("brk_bi", e.bi, 1'b1);
         check("brk_latency", e.idx - ei, 8 + 16 * 10);
      end
      evq.delete();
      rx = 1'b1;
      wait_pulses(32);
      check("brk_no_second_push", evq.size(), 0);
      pb = exp_parity(8'h3C, 8, eps, sticky_parity);
      send_frame(8'h3C, pb, 1'b1, ei);
      expect_frame("after_brk", 8'h3C, pb, 1'b1, ei);

      // Reset mid-frame during data bit 3 (line high through the rest of the frame)
      wls = 2'b11; pen = 1'b0; eps = 1'b0;
      wait_pulses(1);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rx = 1'b1;
      wait_pulses(8);
      rst_n = 1'b0;
      wait_pulses(2);
      check("midrst_dout", dout, 8'h00);
      rst_n = 1'b1;
      wait_pulses(6 + 16 * 5 + 32);
      check("midrst_no_push", evq.size(), 0);
      send_frame(8'hC3, 1'b0, 1'b1, ei);
      expect_frame("fc3", 8'hC3, 1'b0, 1'b1, ei);

      // Random frames
      for (int k = 0; k < 10; k++) begin
         wls = 2'($urandom_range(0, 3));
         pen = 1'($urandom_range(0, 1));
         eps = 1'($urandom_range(0, 1));
         sticky_parity = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         sb = ($urandom_range(0, 3) != 0);
         send_frame(d, pb, sb, ei);
         expect_frame($sformatf("rnd%0d", k), d, pb, sb, ei);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
